// File: rtl/dm_responder.sv
// Data-memory responder for the M stage: one word request at a time, programmable
// wait states, one-cycle ready pulse. Optional write trace enabled by DM_TRACE_EN.
module dm_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  we_q;
    logic [31:2]           addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  accept;
    logic [31:0]           mem [DEPTH];

    assign idx_q  = addr_q[ADDR_WIDTH+1:2];
    assign accept = (state == IDLE) && req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured only on accept so initiator changes while busy are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr[31:2];
            be_q    <= be;
            wdata_q <= wdata;
        end
    end

    always_comb begin
        merged = mem[idx_q];
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // The merged word equals the stored word when be=0, so a blank write is harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == RESP && we_q) begin
            mem[idx_q] <= merged;
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE) || req;
    assign rdata = ready ? mem[idx_q] : 32'h0;

`ifdef DM_TRACE_EN
    logic [31:0] pc_q;
    logic        unused_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (accept) begin
            pc_q <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && state == RESP && we_q && be_q != 4'h0) begin
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
        end
    end

    assign unused_ok = ^addr[1:0];
`else
    logic unused_ok;

    assign unused_ok = ^{addr[1:0], addr_q[31:ADDR_WIDTH+2], pc};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: directed transactions push expected read
// data into a queue; a monitor pops and compares on every ready pulse.
module tb_dm_responder;

    localparam int ADDR_WIDTH  = 10;
    localparam int WAIT_CYCLES = 2;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ready;
    logic [31:0] rdata;
    logic        busy;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    logic prev_ready;

    dm_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .we   (we),
        .addr (addr),
        .be   (be),
        .wdata(wdata),
        .pc   (pc),
        .ready(ready),
        .rdata(rdata),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every ready pulse consumes one scoreboard entry; rdata must be 0 outside RESP.
    always @(negedge clk) begin
        if (reset) begin
            if (ready) begin
                checkOutput("ready_single_cycle", {31'b0, prev_ready}, 32'h0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ready", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.chk) begin
                        checkOutput("rdata", rdata, e.data);
                    end
                end
            end else begin
                checkOutput("rdata_idle_zero", rdata, 32'h0);
            end
            prev_ready <= ready;
        end else begin
            prev_ready <= 1'b0;
        end
    end

    // One full transaction: drive at negedge, count edges to ready, then release req.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] b,
                                 input logic [31:0] d, input logic [31:0] exp_rd);
        int   cycles;
        logic seen;
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        pc    = 32'h0000_1000 + a;
        e.chk  = !w;
        e.data = exp_rd;
        sb.push_back(e);
        #1;
        checkOutput("busy_at_accept", {31'b0, busy}, 32'h1);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) begin
                req   = 1'b0;
                wdata = ~d;
                be    = ~b;
            end
            if (ready) seen = 1'b1;
        end
        checkOutput("ready_latency", 32'(cycles), 32'(WAIT_CYCLES + 1));
        @(posedge clk);
        #1;
        checkOutput("busy_after_resp", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int rdy_count;
        int rdy_first;
        int rdy_second;
        exp_t e;

        vectors     = 0;
        miscompares = 0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        pc    = '0;
        reset = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", {31'b0, ready}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0000_0FFC, 4'hF, 32'h0, 32'h0000_0000);

        applyStimulus(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678, 32'h0);
        applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_5678);

        applyStimulus(1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AB, 32'h0);
        applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h1234_56AB);

        applyStimulus(1'b1, 32'h0000_0022, 4'b1100, 32'hCAFE_0000, 32'h0);
        applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'hCAFE_0000);

        applyStimulus(1'b1, 32'h0000_0000, 4'hF, 32'h55AA_0001, 32'h0);
        applyStimulus(1'b0, 32'h0000_1000, 4'h0, 32'h0, 32'h55AA_0001);
        applyStimulus(1'b1, 32'h0000_1004, 4'h0, 32'hFFFF_FFFF, 32'h0);
        applyStimulus(1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0000_0013, 4'h0, 32'h0, 32'h1234_56AB);

        // Two reads with req held high throughout; address changes after the first ready.
        e.chk = 1'b1;
        e.data = 32'h1234_56AB;
        sb.push_back(e);
        e.data = 32'hCAFE_0000;
        sb.push_back(e);
        rdy_count  = 0;
        rdy_first  = -1;
        rdy_second = -1;
        @(negedge clk);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h0000_0010;
        be   = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                rdy_count++;
                if (rdy_count == 1) begin
                    rdy_first = i;
                    addr = 32'h0000_0020;
                end else if (rdy_count == 2) begin
                    rdy_second = i;
                    req = 1'b0;
                end
            end
        end
        checkOutput("b2b_ready_count", 32'(rdy_count), 32'd2);
        checkOutput("b2b_first_ready", 32'(rdy_first), 32'd2);
        checkOutput("b2b_second_ready", 32'(rdy_second), 32'd6);

        // Reset during WAIT of a write: no ready, memory cleared.
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h0000_0040;
        be    = 4'hF;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("abort_ready", {31'b0, ready}, 32'h0);
        checkOutput("abort_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0000_0000);
        applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0000_0000);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
